// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: shares one active-low NAND SR latch among N_REQ requesters.
// Round-robin arbitration over level set/clear requests, fixed-width registered
// drive pulses, a settle gap, then a check of the latch output against the value
// the last transaction should have left behind. sbar/rbar are never both low.
module sr_latch_arbiter #(
   parameter int N_REQ        = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] set_req,
   input  logic [N_REQ-1:0] clr_req,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic             sbar,
   output logic             rbar,
   input  logic             q_fb,
   output logic             expected,
   output logic             mismatch,
   output logic             conflict
);

   localparam int PW   = $clog2(N_REQ);
   localparam int PMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CMAX = (PMAX > 2) ? PMAX : 2;
   localparam int CW   = $clog2(CMAX);

   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] LAST_IDX   = PW'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_DRIVE,
      ST_GAP,
      ST_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;
   logic             sbar_q, sbar_d;
   logic             rbar_q, rbar_d;
   logic             expected_q, expected_d;
   logic             mismatch_q, mismatch_d;
   logic             conflict_q, conflict_d;

   logic [N_REQ-1:0] valid;
   logic [N_REQ-1:0] both;
   logic [PW-1:0]    cand_idx [N_REQ];
   logic             win_found;
   logic [PW-1:0]    win_idx;

   // Per-requester decode and the rotated scan order starting at ptr.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign valid[gi]    = set_req[gi] ^ clr_req[gi];
      assign both[gi]     = set_req[gi] & clr_req[gi];
      assign cand_idx[gi] = PW'((int'(ptr_q) + gi) % N_REQ);
   end

   // Round-robin pick: first valid requester in scan order from ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!win_found && valid[cand_idx[k]]) begin
            win_found = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   // Next-state and next-output logic; drive values are precomputed so the
   // latch pins come straight from flops. A single request's set bit feeds
   // sbar/rbar complementarily, so both-low is unreachable from every state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      grant_d    = '0;
      busy_d     = busy_q;
      sbar_d     = sbar_q;
      rbar_d     = rbar_q;
      expected_d = expected_q;
      mismatch_d = mismatch_q;
      conflict_d = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
               sbar_d  = 1'b1;
               rbar_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q - 1'b1;
               sbar_d = 1'b1;
               rbar_d = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
               sbar_d  = 1'b1;
               rbar_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               if (q_fb != expected_q) begin
                  mismatch_d = 1'b1;
               end
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_IDLE: begin
            conflict_d = |both;
            sbar_d     = 1'b1;
            rbar_d     = 1'b1;
            busy_d     = 1'b0;
            if (win_found) begin
               state_d    = ST_DRIVE;
               cnt_d      = PULSE_LOAD;
               busy_d     = 1'b1;
               grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
               expected_d = set_req[win_idx];
               sbar_d     = ~set_req[win_idx];
               rbar_d     = set_req[win_idx];
               ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = PULSE_LOAD;
            busy_d  = 1'b1;
            sbar_d  = 1'b1;
            rbar_d  = 1'b0;
         end
      endcase
   end

   // State register; reset parks the latch in the cleared drive immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         cnt_q      <= PULSE_LOAD;
         ptr_q      <= '0;
         grant_q    <= '0;
         busy_q     <= 1'b1;
         sbar_q     <= 1'b1;
         rbar_q     <= 1'b0;
         expected_q <= 1'b0;
         mismatch_q <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         sbar_q     <= sbar_d;
         rbar_q     <= rbar_d;
         expected_q <= expected_d;
         mismatch_q <= mismatch_d;
         conflict_q <= conflict_d;
      end
   end

   assign grant    = grant_q;
   assign busy     = busy_q;
   assign sbar     = sbar_q;
   assign rbar     = rbar_q;
   assign expected = expected_q;
   assign mismatch = mismatch_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Testbench for sr_latch_arbiter: directed transactions with a scoreboard of
// expected grants, a behavioural NAND latch on q_fb, and a both-low watch.
module tb_sr_latch_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] set_req;
   logic [3:0] clr_req;
   logic [3:0] grant;
   logic       busy;
   logic       sbar;
   logic       rbar;
   logic       q_fb;
   logic       expected;
   logic       mismatch;
   logic       conflict;

   int         n_vec = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   logic       mon_en   = 1'b0;
   logic       force_q0 = 1'b0;
   logic       latch_q  = 1'b0;
   logic [5:0] sb [$];

   sr_latch_arbiter #(
      .N_REQ(4),
      .PULSE_CYCLES(2),
      .GAP_CYCLES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .set_req(set_req),
      .clr_req(clr_req),
      .grant(grant),
      .busy(busy),
      .sbar(sbar),
      .rbar(rbar),
      .q_fb(q_fb),
      .expected(expected),
      .mismatch(mismatch),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural NAND SR latch; force_q0 models a stuck/broken latch.
   always @(sbar or rbar) begin
      if (sbar === 1'b0) latch_q = 1'b1;
      else if (rbar === 1'b0) latch_q = 1'b0;
   end
   assign q_fb = force_q0 ? 1'b0 : latch_q;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Both-low watch on every falling edge and just after every reset assertion.
   always @(negedge clk) chk1("no_both_low", (sbar === 1'b0 && rbar === 1'b0), 1'b0);
   always @(posedge rst) begin
      #1;
      chk1("no_both_low_rst", (sbar === 1'b0 && rbar === 1'b0), 1'b0);
   end

   // Monitor: every grant pops the scoreboard and is compared against it.
   always @(negedge clk) begin
      logic [5:0] rec;
      if (mon_en && ((|grant) === 1'b1)) begin
         if (sb.size() == 0) begin
            chk4("unexpected_grant", grant, 4'b0000);
         end else begin
            rec = sb.pop_front();
            chk4("grant", grant, rec[5:2]);
            chk1("expected", expected, rec[1]);
            chk1("conflict", conflict, rec[0]);
            $display("txn: grant=%b expected=%b conflict=%b cyc=%0d", grant, expected, conflict, cyc);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk1({tag, "_sbar"}, sbar, 1'b1);
      chk1({tag, "_rbar"}, rbar, 1'b0);
      chk4({tag, "_grant"}, grant, 4'b0000);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_expected"}, expected, 1'b0);
      chk1({tag, "_mismatch"}, mismatch, 1'b0);
      chk1({tag, "_conflict"}, conflict, 1'b0);
   endtask

   task automatic wait_grant(output int at);
      logic found;
      found = 1'b0;
      at    = -1;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge clk);
         if ((|grant) === 1'b1) begin
            found = 1'b1;
            at    = cyc;
         end
      end
      if (!found) begin
         n_vec++;
         n_bad++;
         $display("FAIL grant_timeout: got no grant within 20 cycles (t=%0t)", $time);
      end
   endtask

   task automatic wait_idle();
      logic idle;
      idle = 1'b0;
      for (int t = 0; t < 20 && !idle; t++) begin
         @(negedge clk);
         if (busy === 1'b0) idle = 1'b1;
      end
      chk1("idle_reached", idle, 1'b1);
   endtask

   // One full transaction from IDLE: grant, pulse, gap, back to IDLE.
   task automatic txn(input logic [3:0] s, input logic [3:0] c,
                      input logic [3:0] g, input logic ev, input logic cf);
      int at;
      sb.push_back({g, ev, cf});
      set_req = s;
      clr_req = c;
      wait_grant(at);
      set_req = '0;
      clr_req = '0;
      chk1("pulse1_sbar", sbar, !ev);
      chk1("pulse1_rbar", rbar, ev);
      chk1("drive_busy", busy, 1'b1);
      @(negedge clk);
      chk4("grant_one_cycle", grant, 4'b0000);
      chk1("conflict_one_cycle", conflict, 1'b0);
      chk1("pulse2_sbar", sbar, !ev);
      chk1("pulse2_rbar", rbar, ev);
      @(negedge clk);
      chk1("gap_sbar", sbar, 1'b1);
      chk1("gap_rbar", rbar, 1'b1);
      chk1("gap_busy", busy, 1'b1);
      @(negedge clk);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_expected", expected, ev);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish by 100000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int at;
      int last;
      rst     = 1'b0;
      set_req = '0;
      clr_req = '0;

      // Reset asserted mid-cycle, released after three cycles.
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk1("init_e1_rbar", rbar, 1'b0);
      chk1("init_e1_sbar", sbar, 1'b1);
      chk1("init_e1_busy", busy, 1'b1);
      @(negedge clk);
      chk1("init_gap_sbar", sbar, 1'b1);
      chk1("init_gap_rbar", rbar, 1'b1);
      chk1("init_gap_busy", busy, 1'b1);
      @(negedge clk);
      chk1("init_idle_busy", busy, 1'b0);
      chk1("init_mismatch", mismatch, 1'b0);
      mon_en = 1'b1;

      // Single set from requester 2 (ptr 0 -> 3).
      txn(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0);
      chk1("set_mismatch", mismatch, 1'b0);

      // Requester 1 asserts both (ignored, conflict), requester 3 clears (ptr -> 0).
      txn(4'b0010, 4'b1010, 4'b1000, 1'b0, 1'b1);

      // Everyone holds set: grants 0,1,2,3,0 four cycles apart (ptr -> 1).
      for (int i = 0; i < 5; i++) sb.push_back({4'(1 << (i % 4)), 1'b1, 1'b0});
      set_req = 4'hF;
      last = 0;
      for (int i = 0; i < 5; i++) begin
         wait_grant(at);
         if (i > 0) chk_int("rr_spacing", at - last, 4);
         last = at;
      end
      set_req = '0;
      wait_idle();

      // Only clr_req[0] with ptr at 1: scan wraps to 0 (ptr -> 1).
      txn(4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0);

      // Broken latch on a set: mismatch latches (ptr -> 2).
      force_q0 = 1'b1;
      txn(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0);
      chk1("mismatch_set", mismatch, 1'b1);
      force_q0 = 1'b0;

      // Healthy transactions keep mismatch sticky (ptr -> 3, then -> 1).
      txn(4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0);
      chk1("mismatch_sticky1", mismatch, 1'b1);
      txn(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0);
      chk1("mismatch_sticky2", mismatch, 1'b1);

      // Reset mid-DRIVE: abort, clear mismatch, no grant re-issued.
      sb.push_back({4'b0100, 1'b1, 1'b0});
      set_req = 4'b0100;
      wait_grant(at);
      set_req = '0;
      #2 rst = 1'b1;
      #1 check_reset_vals("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk1("abort_idle_busy", busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk4("abort_no_regrant", grant, 4'b0000);
      end

      // ptr restarted at 0: requesters 1 and 3 pending, 1 wins.
      txn(4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b0);
      chk_int("sb_drained", sb.size(), 0);

      // Random requests and resets: only the both-low watch applies here.
      mon_en = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         set_req = 4'($urandom());
         clr_req = 4'($urandom());
         if ($urandom_range(0, 39) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      set_req = '0;
      clr_req = '0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
